// File: rtl/debounce_pkg.sv
// Shared constants and width helpers for the debounce bank.
package debounce_pkg;

    localparam int MIN_DEBOUNCE_LIMIT = 2;
    localparam int MIN_SYNC_STAGES    = 2;

    // Stability counter only has to reach limit-1.
    function automatic int cnt_width(input int limit);
        return (limit < 2) ? 1 : $clog2(limit);
    endfunction

    // Hold counter saturates at limit, so it must hold the value itself.
    function automatic int hold_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: synchroniser, stability counter, edge pulses and,
// when DEBOUNCE_HOLD_EN is defined, a long-press hold counter.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int   DEBOUNCE_LIMIT = 20,
    parameter int   SYNC_STAGES    = 2,
    parameter int   HOLD_LIMIT     = 1000,
    parameter logic INIT_STATE     = 1'b0
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Bouncy,
    output logic o_Debounced,
    output logic o_Rise,
    output logic o_Fall,
    output logic o_Held
);

    localparam int            CW       = cnt_width(DEBOUNCE_LIMIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_LIMIT - 1);

    if (HOLD_LIMIT < 1) begin : g_bad_hold
        $error("debounce_channel: HOLD_LIMIT must be >= 1");
    end

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   state_q, state_d;
    logic                   prev_q, prev_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   sync;

    assign sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], i_Bouncy};
        state_d = state_q;
        cnt_d   = cnt_q;
        prev_d  = state_q;
        // Any agreeing sample restarts the count; a full run of disagreement flips state.
        if (sync == state_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            state_d = sync;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        rise_d = state_q & ~prev_q;
        fall_d = ~state_q & prev_q;
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            sync_q  <= {SYNC_STAGES{INIT_STATE}};
            cnt_q   <= '0;
            state_q <= INIT_STATE;
            prev_q  <= INIT_STATE;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            prev_q  <= prev_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign o_Debounced = state_q;
    assign o_Rise      = rise_q;
    assign o_Fall      = fall_q;

`ifdef DEBOUNCE_HOLD_EN
    localparam int            HW       = hold_width(HOLD_LIMIT);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_LIMIT);

    logic [HW-1:0] hold_q, hold_d;
    logic          hit_q, hit_d;
    logic          held_q, held_d;

    always_comb begin
        hold_d = '0;
        if (state_q) begin
            hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;
        end
        // Pulse on the first cycle the saturated value is seen.
        hit_d  = (hold_q == HOLD_MAX);
        held_d = hit_d & ~hit_q;
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            hold_q <= '0;
            hit_q  <= 1'b0;
            held_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            hit_q  <= hit_d;
            held_q <= held_d;
        end
    end

    assign o_Held = held_q;
`else
    assign o_Held = 1'b0;
`endif

endmodule

// File: rtl/debounce_bank.sv
// NUM_CH independent debounce channels. Long-press detection is built only
// when DEBOUNCE_HOLD_EN is defined; otherwise o_Held is tied low.
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int                NUM_CH         = 4,
    parameter int                DEBOUNCE_LIMIT = 20,
    parameter int                SYNC_STAGES    = 2,
    parameter logic [NUM_CH-1:0] INIT_STATE     = '0,
    parameter int                HOLD_LIMIT     = 1000
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    input  logic [NUM_CH-1:0] i_Bouncy,
    output logic [NUM_CH-1:0] o_Debounced,
    output logic [NUM_CH-1:0] o_Rise,
    output logic [NUM_CH-1:0] o_Fall,
    output logic [NUM_CH-1:0] o_Held
);

    if (DEBOUNCE_LIMIT < MIN_DEBOUNCE_LIMIT) begin : g_bad_limit
        $error("debounce_bank: DEBOUNCE_LIMIT must be >= 2");
    end
    if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_bad_sync
        $error("debounce_bank: SYNC_STAGES must be >= 2");
    end

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_LIMIT (DEBOUNCE_LIMIT),
            .SYNC_STAGES    (SYNC_STAGES),
            .HOLD_LIMIT     (HOLD_LIMIT),
            .INIT_STATE     (INIT_STATE[n])
        ) u_ch (
            .i_Clk       (i_Clk),
            .i_Rst       (i_Rst),
            .i_Bouncy    (i_Bouncy[n]),
            .o_Debounced (o_Debounced[n]),
            .o_Rise      (o_Rise[n]),
            .o_Fall      (o_Fall[n]),
            .o_Held      (o_Held[n])
        );
    end

endmodule

// File: tb/tb_debounce_bank.sv
// Randomised and directed bench for debounce_bank against a run-length model.
module tb_debounce_bank;

    localparam int         NCH  = 4;
    localparam int         DL   = 4;
    localparam int         SS   = 2;
    localparam int         HL   = 10;
    localparam logic [3:0] INIT = 4'b0100;

    logic           clk = 1'b0;
    logic           rst;
    logic [NCH-1:0] bouncy;
    logic [NCH-1:0] deb, rise, fall, held;

    int n_chk = 0;
    int n_err = 0;

    debounce_bank #(
        .NUM_CH(NCH), .DEBOUNCE_LIMIT(DL), .SYNC_STAGES(SS),
        .INIT_STATE(INIT), .HOLD_LIMIT(HL)
    ) dut (
        .i_Clk(clk), .i_Rst(rst), .i_Bouncy(bouncy),
        .o_Debounced(deb), .o_Rise(rise), .o_Fall(fall), .o_Held(held)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    // Model: state flips after DL consecutive synchronised disagreements.
    logic           pipe_m [NCH][SS];
    logic           state_m[NCH];
    int             run_m  [NCH];
    int             age_m  [NCH];
    logic           up_m   [NCH];
    logic           dn_m   [NCH];
    logic           reach_m[NCH];
    logic [NCH-1:0] e_deb, e_rise, e_fall, e_held;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int n = 0; n < NCH; n++) begin
            for (int k = 0; k < SS; k++) pipe_m[n][k] = INIT[n];
            state_m[n] = INIT[n];
            run_m[n]   = 0;
            age_m[n]   = 0;
            up_m[n]    = 1'b0;
            dn_m[n]    = 1'b0;
            reach_m[n] = 1'b0;
        end
        e_deb = INIT; e_rise = '0; e_fall = '0; e_held = '0;
    endtask

    task automatic model_edge(input logic [NCH-1:0] v);
        for (int n = 0; n < NCH; n++) begin
            logic s;
            s = pipe_m[n][SS-1];
            e_rise[n] = up_m[n];
            e_fall[n] = dn_m[n];
`ifdef DEBOUNCE_HOLD_EN
            e_held[n] = reach_m[n];
`else
            e_held[n] = 1'b0;
`endif
            age_m[n]   = state_m[n] ? age_m[n] + 1 : 0;
            reach_m[n] = (age_m[n] == HL);
            up_m[n] = 1'b0;
            dn_m[n] = 1'b0;
            if (s != state_m[n]) begin
                run_m[n]++;
                if (run_m[n] == DL) begin
                    state_m[n] = s;
                    run_m[n]   = 0;
                    up_m[n]    = s;
                    dn_m[n]    = !s;
                end
            end else begin
                run_m[n] = 0;
            end
            for (int k = SS - 1; k > 0; k--) pipe_m[n][k] = pipe_m[n][k-1];
            pipe_m[n][0] = v[n];
            e_deb[n] = state_m[n];
        end
    endtask

    task automatic check_all();
        chk("deb",  32'(deb),  32'(e_deb));
        chk("rise", 32'(rise), 32'(e_rise));
        chk("fall", 32'(fall), 32'(e_fall));
        chk("held", 32'(held), 32'(e_held));
        chk("excl", 32'(rise & fall), 32'd0);
    endtask

    // Drive v across one rising edge, then compare on the falling edge.
    task automatic cyc(input logic [NCH-1:0] v);
        bouncy = v;
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge(v);
        @(negedge clk);
        check_all();
    endtask

    task automatic full_reset();
        rst    = 1'b1;
        bouncy = INIT;
        model_reset();
        cyc(INIT);
        cyc(INIT);
        #2 rst = 1'b0;
    endtask

    initial begin
        logic [NCH-1:0] v;
        int lat, rc, fc, nheld;

        rst    = 1'b1;
        bouncy = INIT;
        model_reset();
        #1;
        chk("rst_deb", 32'(deb), 32'(INIT));
        @(negedge clk);
        full_reset();

        // Clean step on ch0.
        v = INIT | 4'b0001; lat = 0;
        for (int k = 1; k <= 20; k++) begin
            cyc(v);
            if (deb[0] && lat == 0) lat = k;
        end
        chk("step_lat", 32'(lat), 32'd6);

        // Glitch on ch1: 3 high, 1 low, 3 high.
        for (int k = 0; k < 3; k++) cyc(v | 4'b0010);
        cyc(v);
        for (int k = 0; k < 3; k++) cyc(v | 4'b0010);
        for (int k = 0; k < 10; k++) cyc(v);
        chk("glitch", 32'(deb[1]), 32'd0);

        // Simultaneous ch0 rise and ch2 fall.
        for (int k = 0; k < 12; k++) cyc(INIT);
        rc = 0; fc = 0;
        for (int k = 1; k <= 12; k++) begin
            cyc(4'b0001);
            if (rise[0]) rc = k;
            if (fall[2]) fc = k;
        end
        chk("simul_rise", 32'(rc), 32'd7);
        chk("simul_same", 32'(fc), 32'(rc));

        // Long press on ch3, twice.
        nheld = 0;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 30; k++) begin cyc(4'b1001); nheld += int'(held[3]); end
            for (int k = 0; k < 12; k++) begin cyc(4'b0001); nheld += int'(held[3]); end
        end
`ifdef DEBOUNCE_HOLD_EN
        chk("held_cnt", 32'(nheld), 32'd2);
`else
        chk("held_cnt", 32'(nheld), 32'd0);
`endif

        // Randomised toggling; ch3 toggles rarely so long presses occur.
        v = INIT;
        for (int k = 0; k < 600; k++) begin
            for (int n = 0; n < NCH; n++)
                if ($urandom_range(0, (n == 3) ? 39 : 7) == 0) v[n] = ~v[n];
            cyc(v);
        end

        // Asynchronous reset between edges.
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("arst_deb",  32'(deb),  32'(INIT));
        chk("arst_rise", 32'(rise), 32'd0);
        chk("arst_fall", 32'(fall), 32'd0);
        chk("arst_held", 32'(held), 32'd0);
        @(negedge clk);
        cyc(INIT);
        #2 rst = 1'b0;

        // Reset pulse in the middle of a ch0 count.
        v = INIT | 4'b0001;
        for (int k = 0; k < 3; k++) cyc(v);
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        model_reset();
        lat = 0; rc = 0;
        for (int k = 1; k <= 12; k++) begin
            cyc(v);
            if (deb[0] && lat == 0) lat = k;
            if (rise[0] && rc == 0) rc = k;
        end
        chk("rst_mid_lat",  32'(lat), 32'd6);
        chk("rst_mid_rise", 32'(rc),  32'd7);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/debounce_bank.md
# debounce_bank

Multi-channel debouncer for push-buttons and mechanical switches. Each of `NUM_CH` asynchronous inputs is synchronised, then filtered with a per-channel stability counter. Each channel also produces one-cycle rise/fall pulses and an optional long-press pulse. It sits between the board I/O pins and the user-logic FSMs, and replaces single-channel debounce instances.

## Interface
- `NUM_CH`, 4: number of independent channels, ≥1
- `DEBOUNCE_LIMIT`, 20: consecutive stable cycles required to accept a change, ≥2
- `SYNC_STAGES`, 2: synchroniser flops per channel, ≥2
- `INIT_STATE`, all 0: `NUM_CH`-bit reset value of the debounced state
- `HOLD_LIMIT`, 1000: cycles of continuous high state before `o_Held` fires, ≥1; used only with `DEBOUNCE_HOLD_EN`
- `i_Clk`  in  1  single clock, all logic on its rising edge
- `i_Rst`  in  1  asynchronous, active-high reset
- `i_Bouncy`  in  `NUM_CH`  raw asynchronous inputs
- `o_Debounced`  out  `NUM_CH`  filtered state per channel
- `o_Rise`  out  `NUM_CH`  one-cycle pulse on accepted 0→1
- `o_Fall`  out  `NUM_CH`  one-cycle pulse on accepted 1→0
- `o_Held`  out  `NUM_CH`  one-cycle long-press pulse

## Operation
- Channels are fully independent; there is no cross-channel interaction.
- Synchroniser: a `SYNC_STAGES`-deep shift of `i_Bouncy[n]`. The last stage is `sync[n]`.
- Stability counter `cnt[n]`, width `$clog2(DEBOUNCE_LIMIT)`:
  - When `sync == state` and `cnt < DEBOUNCE_LIMIT-1`: `cnt <= 0`.
  - When `sync != state` and `cnt < DEBOUNCE_LIMIT-1`: `cnt <= cnt+1`.
  - When `sync != state` and `cnt == DEBOUNCE_LIMIT-1`: `state <= sync` and `cnt <= 0`.
  - Any single cycle of `sync == state` during counting restarts the count from 0.
  - `cnt` never exceeds `DEBOUNCE_LIMIT-1`, so there is no wrap-around.
- Edge pulses:
  - `o_Rise[n]` is registered high for exactly the one cycle after the state flips 0→1.
  - `o_Fall[n]` is the same for 1→0.
  - `o_Rise` and `o_Fall` are never both high on the same channel.
- Long press (only with the macro):
  - `hold[n]` counts while `state == 1`. It saturates at `HOLD_LIMIT`.
  - `o_Held[n]` pulses once, in the cycle after `hold` reaches `HOLD_LIMIT`.
  - `hold` clears when `state == 0`, so a new press re-arms the pulse.
- Reset (asynchronous, `i_Rst = 1`):
  - Synchroniser flops ← `INIT_STATE`.
  - `state` ← `INIT_STATE`.
  - `cnt` and `hold` ← 0.
  - `o_Rise`, `o_Fall`, `o_Held` ← 0.
  - `o_Debounced` = `INIT_STATE`.
  - A count in progress when reset asserts is discarded; after reset deasserts, no edge pulse is emitted for it.
- Reset release: take the first counting edge as the first rising `i_Clk` edge after deassertion. The reset deassertion itself is synchronised externally.

## Timing
- Latency from a clean `i_Bouncy` step to `o_Debounced` changing is exactly `SYNC_STAGES + DEBOUNCE_LIMIT` cycles.
- The `o_Rise`/`o_Fall` pulse follows one cycle after `o_Debounced` changes.
- `o_Held` asserts `HOLD_LIMIT + 1` cycles after `o_Debounced` rises.
- A glitch of `DEBOUNCE_LIMIT-1` or fewer synchronised cycles never changes the output.
- If `i_Bouncy` changes on the same cycle that the count completes, the count still completes. The new value starts its own count in the following cycle.
- All outputs are registered; there are no combinational paths from input to output.

## Configuration
- `DEBOUNCE_HOLD_EN` defined:
  - The `hold` counters and `o_Held` logic are instantiated, one per channel.
  - Counter width is `$clog2(HOLD_LIMIT+1)`.
- `DEBOUNCE_HOLD_EN` undefined:
  - No hold counters are generated.
  - The `o_Held` port remains, tied to constant 0.
  - `HOLD_LIMIT` is ignored.

## Structure
- Package `debounce_pkg`:
  - Width helper functions for `cnt` and `hold`.
  - Parameter-legality constants: minimum `DEBOUNCE_LIMIT` and minimum `SYNC_STAGES`.
- Sub-module `debounce_channel`:
  - Contains one synchroniser, one stability counter, edge pulses and the optional hold counter.
  - `debounce_bank` is a generate loop of `NUM_CH` instances.
- The top level elaborates with an error for `DEBOUNCE_LIMIT < 2` or `SYNC_STAGES < 2`.

## Test plan
Bench parameters: `NUM_CH=4`, `DEBOUNCE_LIMIT=4`, `SYNC_STAGES=2`, `HOLD_LIMIT=10`, `INIT_STATE=4'b0100`.

1. Reset: assert `i_Rst` mid-simulation, off clock edge → outputs update immediately to `o_Debounced=4'b0100`, with `o_Rise`, `o_Fall`, `o_Held` = 0.
2. Clean step: `i_Bouncy[0]` goes 0→1 and holds → `o_Debounced[0]` rises on cycle 6. `o_Rise[0]` is high only on cycle 7. Other channels stay unchanged.
3. Glitch rejection: `i_Bouncy[1]` high for 3 cycles, low for 1, high for 3 → no change on `o_Debounced[1]` and no pulses.
4. Simultaneous channels: ch0 rises and ch2 falls on the same cycle → `o_Rise[0]` and `o_Fall[2]` pulse on the same cycle. No other pulses.
5. Long press with `DEBOUNCE_HOLD_EN`: hold ch3 high for 30 cycles → one `o_Held[3]` pulse, 11 cycles after `o_Debounced[3]` rises. Release and re-press → a second pulse. Without the macro, `o_Held` stays 0 throughout.
6. Reset mid-count: `i_Bouncy[0]` high for 3 cycles, then pulse `i_Rst` → after release, counting restarts and `o_Debounced[0]` rises 6 cycles later. No stale `o_Rise` pulse.
